mem_responder: RTL

Word-addressed data-memory responder for the processor's load/store port, with a registered request/acknowledge handshake and a configurable number of wait states. It replaces the zero-latency combinational data memory when the core or bench must tolerate slow memory. It accepts one transfer at a time, commits writes, returns read data with the acknowledge, and flags misaligned or out-of-range addresses without touching storage.

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
// Also holds the address legality check used by the responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0;

  // A byte address is rejected when misaligned or when its word index is past the array.
  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for the responder: synchronous write, combinational read.
// Contents are never initialised or cleared.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int IW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rd = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder with a request/acknowledge handshake and WAIT_CYCLES wait states.
// One transfer in flight; bad addresses are answered with err and never reach storage.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic          cur_we;
  logic [31:0]   cur_addr, cur_wdata;
  logic          cur_bad;
  logic          enter_resp;
  logic          mem_we;
  logic [31:0]   mem_rd;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt == '0) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    ack   = 1'b0;
    err   = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      RESP: begin
        ack = 1'b1;
        err = addr_bad(addr_q, DEPTH);
      end
      default: ;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so look at the live inputs then.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
    end
  end

  assign cur_bad    = addr_bad(cur_addr, DEPTH);
  assign enter_resp = (next_state == RESP) && (state != RESP) && !reset;
  assign mem_we     = enter_resp && cur_we && !cur_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (enter_resp) begin
        if (cur_bad)      rdata <= ERR_RDATA;
        else if (!cur_we) rdata <= mem_rd;
      end
    end
  end

  mem_array #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .clk (clk),
    .we  (mem_we),
    .idx (cur_addr[IW+1:2]),
    .wd  (cur_wdata),
    .rd  (mem_rd)
  );

endmodule
